mem_req_initiator: RTL and testbench
====================================

# mem_req_initiator

Initiator-side controller that drives the `Mem_Subsystem` load/store interface on behalf of a CPU-side requester. It accepts one word request at a time through a valid/ready handshake and checks word alignment. It then holds `LOAD` or `STORE` with a stable address until the subsystem signals completion, and returns read data or an error as a single-cycle response. It sits between the core's load/store stage and `Mem_Subsystem`, and is the synthesizable counterpart of the stimulus the subsystem bench applies by hand.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before a request is aborted; legal range 1..65535.
- `CLK` input 1: single clock; all logic is on the rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `req_valid` input 1: the CPU presents a request.
- `req_ready` output 1: the block can accept a request; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: load data; 0 for stores and errors.
- `resp_err` output 1: qualifies `resp_valid`; misalignment or timeout.
- `input_address` output 32: address to `Mem_Subsystem`.
- `LOAD` output 1: load strobe to `Mem_Subsystem`.
- `STORE` output 1: store strobe to `Mem_Subsystem`.
- `data_out` output 32: store data to `Mem_Subsystem`.
- `data_in` input 32: load data from `Mem_Subsystem`.
- `mem_ready` input 1: the subsystem has completed the current strobe; data is valid in the same cycle.
- `txn_count` output 16: number of completed non-error transactions; wraps modulo 2^16.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the request is accepted. `req_addr`, `req_we` and `req_wdata` are latched.
  - If `req_addr[1:0]`≠0, go to RESP with the error flag set; no strobe is issued.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - `LOAD`=!we and `STORE`=we; the two are never high together.
  - `input_address` and `data_out` hold the latched values, stable throughout WAIT.
  - On `mem_ready`=1, capture `data_in` (loads only) and go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 with `mem_ready`=0, go to RESP with the error flag set.
- RESP:
  - `resp_valid`=1 for exactly one cycle.
  - `resp_err` and `resp_rdata` are driven from the latched values.
  - `txn_count` increments if there is no error.
  - Always return to IDLE.
- `mem_ready` seen outside WAIT is ignored.
- `req_valid` outside IDLE is ignored; `req_ready`=0, so no request is accepted.
- Error responses:
  - `resp_rdata`=0.
  - A timed-out store counts as not performed; no retry.
- When `LOAD`=`STORE`=0, `input_address` and `data_out` still hold the last latched values. Only the strobes qualify them.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `LOAD`=`STORE`=0.
  - `input_address`=0, `data_out`=0, `txn_count`=0, timeout counter=0.
- Reset asserted mid-transaction:
  - Strobes drop at the next edge.
  - No response is produced.
  - `txn_count` is cleared.
- Cycle numbering is relative to the accept edge, cycle 0:
  - The strobe is high from cycle 1.
  - If `mem_ready` is first seen high in cycle k (k≥1), then `resp_valid` is high in cycle k+1 and the strobe is low in cycle k+1.
  - `req_ready` returns high in cycle k+2.
  - Minimum request-to-response latency is 2 cycles, with at least one dead cycle between back-to-back requests.
- Misaligned request: `resp_valid` and `resp_err` are high in cycle 1; no strobe is ever issued.
- Timeout: the strobe is high for exactly `TIMEOUT_CYCLES` cycles (cycles 1..`TIMEOUT_CYCLES`); `resp_err` pulses in cycle `TIMEOUT_CYCLES`+1.
- `mem_ready` and the final timeout cycle coinciding: `mem_ready` wins, and the response is a success.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Load 0x9C263200 with `mem_ready` held low 3 cycles then high for 1 cycle with `data_in`=0xDEADBEEF -> `LOAD` high cycles 1–4 with address stable; `resp_valid` in cycle 5 with `resp_rdata`=0xDEADBEEF and `resp_err`=0; `txn_count`=1.
- Store `req_wdata`=0x12345678 to 0x00000010 with `mem_ready` high in cycle 1 -> `STORE` high only in cycle 1 with `data_out`=0x12345678; `resp_valid` in cycle 2 with `resp_rdata`=0; `LOAD` never high.
- Load from 0x9C263203 -> no strobe; `resp_valid` and `resp_err` high in cycle 1; `txn_count` unchanged.
- `TIMEOUT_CYCLES`=4 with `mem_ready` tied low -> `LOAD` high cycles 1–4; `resp_err` pulses in cycle 5; `req_ready` high in cycle 6. Repeat with `mem_ready` high in cycle 4 -> success response.
- `RST` pulsed in cycle 2 of a load -> strobes 0 in cycle 3, no `resp_valid`, `txn_count`=0; a new request is accepted immediately afterwards.
- `req_valid` held high continuously for back-to-back loads while `mem_ready` is pulsed every WAIT cycle, including `mem_ready` pulses during IDLE -> one response per request and no overlapping strobes; `txn_count` increments by one each; pulses during IDLE have no effect.

Source files
------------

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: drives the Mem_Subsystem LOAD/STORE interface for a
// single CPU-side requester. One word request is in flight at a time. The
// block holds a strobe with a stable address until mem_ready or a timeout,
// then returns a one-cycle response. Every output is a flop.
module mem_req_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] input_address,
   output logic        LOAD,
   output logic        STORE,
   output logic [31:0] data_out,
   input  logic [31:0] data_in,
   input  logic        mem_ready,
   output logic [15:0] txn_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Counter value seen in the last permitted WAIT cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic        we_q;
   logic [15:0] tmo_cnt;

   // Request FSM. All outputs are registered here, so each one reflects
   // the state that is being entered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_rdata    <= '0;
         LOAD          <= 1'b0;
         STORE         <= 1'b0;
         input_address <= '0;
         data_out      <= '0;
         we_q          <= 1'b0;
         tmo_cnt       <= '0;
         txn_count     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  input_address <= req_addr;
                  data_out      <= req_wdata;
                  we_q          <= req_we;
                  tmo_cnt       <= '0;
                  req_ready     <= 1'b0;
                  if (req_addr[1:0] != 2'b00) begin
                     // Misaligned: answer with an error, never touch memory.
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state <= S_WAIT;
                     LOAD  <= ~req_we;
                     STORE <= req_we;
                  end
               end
            end
            S_WAIT: begin
               // mem_ready is tested first, so it wins over a timeout that
               // lands in the same cycle.
               if (mem_ready) begin
                  state      <= S_RESP;
                  LOAD       <= 1'b0;
                  STORE      <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= we_q ? 32'h0 : data_in;
               end else if (tmo_cnt == TMO_LAST) begin
                  // Abort. A timed-out store counts as not performed.
                  state      <= S_RESP;
                  LOAD       <= 1'b0;
                  STORE      <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            S_RESP: begin
               if (!resp_err) txn_count <= txn_count + 16'd1;
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               LOAD       <= 1'b0;
               STORE      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator using a short timeout (4 cycles).
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_mem_req_initiator;

   localparam int TMO = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata, input_address, data_out, data_in;
   logic        LOAD, STORE, mem_ready;
   logic [15:0] txn_count;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_cnt = 16'd0;

   mem_req_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .input_address(input_address), .LOAD(LOAD), .STORE(STORE),
      .data_out(data_out), .data_in(data_in), .mem_ready(mem_ready),
      .txn_count(txn_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // One transaction, starting in an IDLE cycle (cycle 0). k is the cycle in
   // which mem_ready first goes high (0 = never). hold keeps req_valid high
   // afterwards; pulse drives mem_ready high every cycle.
   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] din,
                      input int k, input logic hold, input logic pulse);
      int          rc;
      logic        mis, err;
      logic [31:0] exp_rd;
      mis    = (addr[1:0] != 2'b00);
      err    = mis || !(k >= 1 && k <= TMO);
      rc     = mis ? 1 : (err ? TMO + 1 : k + 1);
      exp_rd = (err || we) ? 32'h0 : din;
      chk({tag, " ready_c0"}, {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      mem_ready = pulse; data_in = 32'h0BAD0000;
      for (int c = 1; c <= rc; c++) begin
         tick;
         if (c < rc) begin
            chk($sformatf("%s c%0d LOAD", tag, c), {31'h0, LOAD}, {31'h0, ~we});
            chk($sformatf("%s c%0d STORE", tag, c), {31'h0, STORE}, {31'h0, we});
            chk($sformatf("%s c%0d addr", tag, c), input_address, addr);
            chk($sformatf("%s c%0d dout", tag, c), data_out, wdata);
            chk($sformatf("%s c%0d rvalid", tag, c), {31'h0, resp_valid}, 32'd0);
            chk($sformatf("%s c%0d ready", tag, c), {31'h0, req_ready}, 32'd0);
         end else begin
            chk($sformatf("%s c%0d rvalid", tag, c), {31'h0, resp_valid}, 32'd1);
            chk($sformatf("%s c%0d rerr", tag, c), {31'h0, resp_err}, {31'h0, err});
            chk($sformatf("%s c%0d rdata", tag, c), resp_rdata, exp_rd);
            chk($sformatf("%s c%0d strobes", tag, c), {30'h0, LOAD, STORE}, 32'd0);
            chk($sformatf("%s c%0d ready", tag, c), {31'h0, req_ready}, 32'd0);
         end
         // Scramble request fields: the latched copies must not follow them.
         req_valid = hold;
         req_addr  = addr ^ 32'h5555_0000;
         req_wdata = ~wdata;
         req_we    = ~we;
         mem_ready = pulse || (c == k);
         data_in   = (c == k) ? din : (32'h0BAD0000 | 32'(c));
      end
      tick;
      if (!err) exp_cnt = exp_cnt + 16'd1;
      chk({tag, " ready_end"}, {31'h0, req_ready}, 32'd1);
      chk({tag, " rvalid_end"}, {31'h0, resp_valid}, 32'd0);
      chk({tag, " strobes_end"}, {30'h0, LOAD, STORE}, 32'd0);
      chk({tag, " txn_count"}, {16'h0, txn_count}, {16'h0, exp_cnt});
   endtask

   initial begin
      RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_wdata = 32'h0; data_in = 32'h0; mem_ready = 1'b0;
      tick; tick;
      chk("rst ready", {31'h0, req_ready}, 32'd1);
      chk("rst rvalid", {31'h0, resp_valid}, 32'd0);
      chk("rst rerr", {31'h0, resp_err}, 32'd0);
      chk("rst rdata", resp_rdata, 32'd0);
      chk("rst strobes", {30'h0, LOAD, STORE}, 32'd0);
      chk("rst addr", input_address, 32'd0);
      chk("rst dout", data_out, 32'd0);
      chk("rst txn_count", {16'h0, txn_count}, 32'd0);
      RST = 1'b0;

      // Load, mem_ready in cycle 4 (also the last timeout cycle: success).
      txn("load_k4", 1'b0, 32'h9C263200, 32'h0, 32'hDEADBEEF, 4, 1'b0, 1'b0);
      // Store completing immediately.
      txn("store_k1", 1'b1, 32'h00000010, 32'h12345678, 32'hCAFEF00D, 1, 1'b0, 1'b0);
      // Misaligned load: error in cycle 1, no strobe, count unchanged.
      txn("misalign", 1'b0, 32'h9C263203, 32'h0, 32'h0, 1, 1'b0, 1'b0);
      // Load timeout: LOAD cycles 1..4, error in cycle 5.
      txn("load_tmo", 1'b0, 32'h00000ABC, 32'h0, 32'h11111111, 0, 1'b0, 1'b0);
      // Load completing one cycle before the timeout.
      txn("load_k3", 1'b0, 32'h80000004, 32'h0, 32'hA5A5C3C3, 3, 1'b0, 1'b0);
      // Store timeout.
      txn("store_tmo", 1'b1, 32'h00000100, 32'hFEEDFACE, 32'h0, 0, 1'b0, 1'b0);

      // Reset mid-load: strobe drops, no response, count cleared.
      chk("rstmid ready_c0", {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00000040;
      tick;
      chk("rstmid c1 LOAD", {31'h0, LOAD}, 32'd1);
      req_valid = 1'b0;
      tick;
      chk("rstmid c2 LOAD", {31'h0, LOAD}, 32'd1);
      RST = 1'b1;
      tick;
      chk("rstmid c3 strobes", {30'h0, LOAD, STORE}, 32'd0);
      chk("rstmid c3 rvalid", {31'h0, resp_valid}, 32'd0);
      chk("rstmid c3 txn_count", {16'h0, txn_count}, 32'd0);
      RST = 1'b0;
      exp_cnt = 16'd0;
      txn("post_rst", 1'b0, 32'h00000044, 32'h0, 32'h76543210, 2, 1'b0, 1'b0);

      // Back-to-back with req_valid held and mem_ready high every cycle.
      txn("b2b_0", 1'b0, 32'h00001000, 32'h0, 32'h00000001, 1, 1'b1, 1'b1);
      txn("b2b_1", 1'b0, 32'h00001004, 32'h0, 32'h00000002, 1, 1'b1, 1'b1);
      txn("b2b_2", 1'b1, 32'h00001009, 32'h99, 32'h0, 1, 1'b1, 1'b1);
      txn("b2b_3", 1'b0, 32'h00001008, 32'h0, 32'h00000003, 1, 1'b1, 1'b1);
      req_valid = 1'b0; mem_ready = 1'b1;
      tick; tick;
      chk("idle_mready rvalid", {31'h0, resp_valid}, 32'd0);
      chk("idle_mready strobes", {30'h0, LOAD, STORE}, 32'd0);
      chk("idle_mready txn_count", {16'h0, txn_count}, {16'h0, exp_cnt});
      mem_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
